// File: rtl/add_round_key.sv
// AES AddRoundKey stage: holds a pre-expanded key schedule loaded one word
// per cycle, XORs each accepted state matrix with the key of the current
// round, and presents the result in one registered output stage with
// valid/ready backpressure. NUM_ROUNDS is expected to be at least 1.
module add_round_key #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_clear,
  input  logic [31:0]           key_word_in,
  input  logic                  key_word_valid,
  output logic                  key_word_ready,
  input  logic [3:0][3:0][7:0]  ark_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [3:0][3:0][7:0]  ark_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_round,
  output logic                  out_last
);

  localparam int NUM_WORDS = 4 * (NUM_ROUNDS + 1);
  localparam int WCW       = $clog2(NUM_WORDS);
  localparam int RKW       = $clog2(NUM_ROUNDS + 1);

  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [3:0]            round_q, round_d;
  logic [3:0][3:0][7:0]  ark_out_q, ark_out_d;
  logic [3:0]            out_round_q, out_round_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;

  logic                  key_wr;
  logic                  accept;
  logic [RKW-1:0]        wr_idx;
  logic [RKW-1:0]        rd_idx;
  logic [3:0][31:0]      rk_col;
  logic [3:0][3:0][7:0]  rk_mat;

  assign key_word_ready = (state_q == S_LOAD);
  assign in_ready       = (state_q == S_RUN) && (!out_valid_q || out_ready);
  assign accept         = in_valid && in_ready && !key_clear;
  assign key_wr         = key_word_valid && (state_q == S_LOAD) && !key_clear && !rst;

  // Word i of the schedule belongs to round key i/4.
  assign wr_idx = RKW'(word_cnt_q >> 2);
  // The key RAM is read one cycle ahead: the address is the round that the
  // next accepted state will use, so the key is already registered when it
  // arrives.
  assign rd_idx = rst ? '0 : RKW'(round_d);

  // One RAM per key column; word i lands in column 3-(i%4).
  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      localparam logic [1:0] COL_SEL = 2'(3 - gi);
      logic [31:0] mem [0:NUM_ROUNDS];
      logic [31:0] rd_q;

      // Column write on key load, registered read of the upcoming round key
      always_ff @(posedge clk) begin
        if (key_wr && (word_cnt_q[1:0] == COL_SEL)) begin
          mem[wr_idx] <= key_word_in;
        end
        rd_q <= mem[rd_idx];
      end

      assign rk_col[gi] = rd_q;
    end

    // Bits [31:24] of a column word are row 3, [7:0] are row 0.
    for (gi = 0; gi < 4; gi++) begin : g_row
      for (gj = 0; gj < 4; gj++) begin : g_byte
        assign rk_mat[gi][gj] = rk_col[gj][8*gi +: 8];
      end
    end
  endgenerate

  // Next-state logic: key loading, round tracking and the output stage
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    round_d     = round_q;
    ark_out_d   = ark_out_q;
    out_round_d = out_round_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if ((state_q == S_LOAD) && key_word_valid) begin
      if (word_cnt_q == WCW'(NUM_WORDS - 1)) begin
        state_d    = S_RUN;
        word_cnt_d = '0;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end

    if (accept) begin
      ark_out_d   = ark_in ^ rk_mat;
      out_round_d = round_q;
      out_last_d  = (round_q == 4'(NUM_ROUNDS));
      out_valid_d = 1'b1;
      round_d     = (round_q == 4'(NUM_ROUNDS)) ? 4'd0 : round_q + 4'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clearing the key drops everything, including a pending output.
    if (key_clear) begin
      state_d     = S_LOAD;
      word_cnt_d  = '0;
      round_d     = '0;
      ark_out_d   = '0;
      out_round_d = '0;
      out_last_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      word_cnt_q  <= '0;
      round_q     <= '0;
      ark_out_q   <= '0;
      out_round_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      round_q     <= round_d;
      ark_out_q   <= ark_out_d;
      out_round_q <= out_round_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ark_out   = ark_out_q;
  assign out_round = out_round_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_round_key.sv
// Directed bench for add_round_key with a scoreboard of expected outputs.
module tb_add_round_key;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 key_clear;
  logic [31:0]          key_word_in;
  logic                 key_word_valid;
  logic                 key_word_ready;
  logic [3:0][3:0][7:0] ark_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0][3:0][7:0] ark_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_round;
  logic                 out_last;

  add_round_key #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .key_clear(key_clear),
    .key_word_in(key_word_in), .key_word_valid(key_word_valid),
    .key_word_ready(key_word_ready),
    .ark_in(ark_in), .in_valid(in_valid), .in_ready(in_ready),
    .ark_out(ark_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_round(out_round), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   r;
    logic         l;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           mdl_round = 0;
  logic [127:0] cur_sched [0:10];
  logic [127:0] cur_blk = '0;

  // Block byte k (k=0 is the MSB byte) sits at row 3-(k%4), col 3-(k/4).
  function automatic logic [127:0] blk2mat(input logic [127:0] b);
    logic [3:0][3:0][7:0] m;
    for (int k = 0; k < 16; k++) m[3 - k % 4][3 - k / 4] = b[127 - 8*k -: 8];
    return m;
  endfunction

  function automatic logic [31:0] wd(input int i);
    return cur_sched[i / 4][127 - 32*(i % 4) -: 32];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop/compare on output handshake, push on input accept.
  always @(negedge clk) begin
    if (rst || key_clear) begin
      sb.delete();
      mdl_round = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", {127'd0, out_valid}, 128'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_data", ark_out, e.d);
          chk("sb_round", {124'd0, out_round}, {124'd0, e.r});
          chk("sb_last", {127'd0, out_last}, {127'd0, e.l});
          $display("txn out: round=%0d last=%0d data=%h", out_round, out_last, ark_out);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.d = blk2mat(cur_blk ^ cur_sched[mdl_round]);
        e.r = 4'(mdl_round);
        e.l = (mdl_round == 10);
        sb.push_back(e);
        mdl_round = (mdl_round == 10) ? 0 : mdl_round + 1;
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic load_words(input int n);
    for (int i = 0; i < n; i++) begin
      key_word_in    = wd(i);
      key_word_valid = 1'b1;
      @(posedge clk); #1;
    end
    key_word_valid = 1'b0;
  endtask

  // Called and returns at posedge+1; optionally checks for no output bubble.
  task automatic send(input logic [127:0] blk, input bit bubble_chk);
    int n;
    cur_blk  = blk;
    ark_in   = blk2mat(blk);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    if (bubble_chk) chk("no_bubble", {127'd0, out_valid}, 128'd1);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; key_clear = 1'b0; key_word_in = '0; key_word_valid = 1'b0;
    ark_in = '0; in_valid = 1'b0; out_ready = 1'b0;
    cur_sched[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    cur_sched[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    cur_sched[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    cur_sched[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    cur_sched[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    cur_sched[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    cur_sched[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    cur_sched[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    cur_sched[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    cur_sched[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    cur_sched[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
    chk("rst_key_ready", {127'd0, key_word_ready}, 128'd1);
    chk("rst_ark_out", ark_out, 128'd0);
    chk("rst_out_round", {124'd0, out_round}, 128'd0);
    chk("rst_out_last", {127'd0, out_last}, 128'd0);
    $display("txn reset done");

    // Load FIPS-197 schedule and run the reference plaintext
    @(posedge clk); #1;
    load_words(44);
    @(negedge clk);
    chk("run_key_ready", {127'd0, key_word_ready}, 128'd0);
    chk("run_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(128'h00112233445566778899aabbccddeeff, 1'b0);
    @(negedge clk);
    chk("fips_valid", {127'd0, out_valid}, 128'd1);
    chk("fips_data", ark_out, blk2mat(128'h00102030405060708090a0b0c0d0e0f0));
    chk("fips_round", {124'd0, out_round}, 128'd0);
    chk("fips_last", {127'd0, out_last}, 128'd0);
    @(posedge clk); #1;

    // Stream: rounds 1..10, then a full 0..10 run, then wrap to 0
    for (int j = 0; j < 22; j++) send({$urandom, $urandom, $urandom, $urandom}, j > 0);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure hold, then simultaneous output and input handshake
    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("hold_valid", {127'd0, out_valid}, 128'd1);
      chk("hold_in_ready", {127'd0, in_ready}, 128'd0);
      if (sb.size() > 0) chk("hold_data", ark_out, sb[0].d);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    @(negedge clk);
    chk("both_hs_valid", {127'd0, out_valid}, 128'd1);
    @(posedge clk); #1;

    // key_clear with a pending output
    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    key_clear = 1'b1;
    @(posedge clk); #1;
    key_clear = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", {127'd0, out_valid}, 128'd0);
    chk("clr_key_ready", {127'd0, key_word_ready}, 128'd1);
    chk("clr_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // New random schedule: partial load, clear, ignored input, full reload
    for (int r = 0; r < 11; r++) cur_sched[r] = {$urandom, $urandom, $urandom, $urandom};
    load_words(20);
    key_clear = 1'b1;
    @(posedge clk); #1;
    key_clear = 1'b0;
    cur_blk = 128'h0123456789abcdeffedcba9876543210;
    ark_in = blk2mat(cur_blk);
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("load_in_ready", {127'd0, in_ready}, 128'd0);
      chk("load_out_valid", {127'd0, out_valid}, 128'd0);
      chk("load_key_ready", {127'd0, key_word_ready}, 128'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    load_words(44);
    @(negedge clk);
    chk("reload_key_ready", {127'd0, key_word_ready}, 128'd0);
    @(posedge clk); #1;
    send(128'h00112233445566778899aabbccddeeff, 1'b0);
    @(negedge clk);
    chk("reload_valid", {127'd0, out_valid}, 128'd1);
    chk("reload_round", {124'd0, out_round}, 128'd0);
    @(posedge clk); #1;

    // Key words in S_RUN are ignored
    for (int j = 0; j < 8; j++) begin
      key_word_in    = $urandom;
      key_word_valid = 1'b1;
      @(negedge clk);
      chk("run_key_ignored", {127'd0, key_word_ready}, 128'd0);
      @(posedge clk); #1;
    end
    key_word_valid = 1'b0;
    for (int j = 0; j < 3; j++) send({$urandom, $urandom, $urandom, $urandom}, j > 0);

    // Drain and confirm every expected output appeared
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'd0);
    chk("final_out_valid", {127'd0, out_valid}, 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_round_key.md
Name: add_round_key

Overview:
- AES AddRoundKey stage. Sits directly downstream of the diffusion stage (shift rows + mix columns) and consumes its 4x4 byte state matrix.
- Holds a pre-expanded key schedule of NUM_ROUNDS+1 round keys, loaded one 32-bit word per cycle.
- XORs each accepted state with the round key for the current round and presents the result in one registered output stage with valid/ready backpressure.
- Tracks the round number per block and flags the final round.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds. Schedule holds NUM_ROUNDS+1 round keys = 4*(NUM_ROUNDS+1) words (44 at default).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- key_clear  in  1  synchronous pulse; discards the loaded schedule and returns to key load.
- key_word_in  in  32  schedule word; bits [31:24] go to row 3, [7:0] to row 0.
- key_word_valid  in  1  key word present.
- key_word_ready  out  1  block accepts key words.
- ark_in  in  8 x [3:0][3:0]  state matrix [row][col]; [3][3] is the top-left byte.
- in_valid  in  1  ark_in valid.
- in_ready  out  1  block accepts a state.
- ark_out  out  8 x [3:0][3:0]  XOR result, same layout as ark_in.
- out_valid  out  1  ark_out valid.
- out_ready  in  1  consumer accepts ark_out.
- out_round  out  4  round index used for ark_out.
- out_last  out  1  out_round == NUM_ROUNDS.

Behaviour:
- Block byte mapping: byte k of a 128-bit block (k=0 is the MSB byte) maps to row 3-(k%4), col 3-(k/4).
- Key word i maps to round key i/4, column 3-(i%4).
- Reset (rst=1 at a clock edge):
  - FSM goes to S_LOAD; word counter, round counter and out_round = 0.
  - out_valid = 0, out_last = 0, ark_out = all zero.
  - Key storage contents are don't-care.
- S_LOAD:
  - key_word_ready = 1, in_ready = 0.
  - Each cycle with key_word_valid=1 writes the word at the counter position and increments the counter.
  - The write of word 4*(NUM_ROUNDS+1)-1 moves the FSM to S_RUN on the next cycle and clears the word counter.
- S_RUN:
  - key_word_ready = 0; key_word_valid is ignored.
  - in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready. On accept:
  - ark_out <= ark_in XOR round_key[round]; out_round <= round; out_last <= (round == NUM_ROUNDS); out_valid <= 1.
  - round <= (round == NUM_ROUNDS) ? 0 : round+1.
- Latency is one cycle from accept to out_valid. Throughput is one state per cycle when out_ready is held at 1.
- Output hold: while out_valid=1 and out_ready=0, ark_out, out_round and out_last stay stable.
- Drain: out_valid clears on an out_ready handshake when there is no simultaneous accept.
- Simultaneous output handshake and accept: out_valid stays 1 and the registers load the new data.
- key_clear (takes priority over every handshake that cycle):
  - Same effect as rst; any pending output is dropped.
  - key_word_valid and in_valid in that cycle are ignored.
- rst or key_clear during S_LOAD restarts loading at word 0. Asserted mid-block, the round counter returns to 0.
- Round counter wraps only after a NUM_ROUNDS accept; no other wrap exists.

Test Plan:
- Reset -> out_valid=0, in_ready=0, key_word_ready=1, ark_out all zero.
- Load 44 words of the FIPS-197 key 000102030405060708090a0b0c0d0e0f expanded schedule (first word 00010203). Then present plaintext 00112233445566778899aabbccddeeff with out_ready=1 -> one cycle later ark_out = 00102030405060708090a0b0c0d0e0f0, out_round=0, out_last=0.
- Stream 11 consecutive states with out_ready=1 -> out_round runs 0..10, out_last=1 only on the 11th, and the 12th accept uses round 0. No bubbles after the first output.
- Hold out_ready=0 with out_valid=1 -> in_ready=0 and ark_out is stable for 5 cycles. Raise out_ready together with in_valid -> both handshakes complete in the same cycle with no data loss.
- Pulse key_clear after 20 key words, or during a pending output -> out_valid=0 and FSM is in S_LOAD. A full 44-word reload followed by a state produces the new key's result at round 0.
- Present key_word_valid in S_RUN and in_valid in S_LOAD -> both are ignored: the schedule is unchanged and no output is produced.
